mvu_job_sched: RTL

MVU_JOB_SCHED -- requirements
Module: mvu_job_sched

---
 rtl/mvu_job_sched_if.sv | 44 ++++
 rtl/mvu_job_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mvu_job_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mvu_job_sched_if
// Description : Bundles the job request and MVU handshake signals of the
//               MVU job scheduler.
//               master : environment side (harts + MVU pool + watchdog limit)
//               slave  : scheduler side
//   req_valid/req_cfg      hart -> scheduler job request, CFGW bits per hart
//   req_ready              scheduler -> hart accept, one-hot or zero
//   mvu_start/mvu_cfg      scheduler -> MVU start pulse and configuration
//   mvu_done               MVU -> scheduler completion pulse
//   mvu_busy               per-MVU "not idle" status
//   done_irq/timeout_err   per-hart completion / watchdog pulses
//   timeout_cycles         watchdog limit, 0 disables
// Revision    : 1.0 - initial release
// ============================================================================
interface mvu_job_sched_if #(
    parameter int NREQ = 8,
    parameter int NMVU = 8,
    parameter int CFGW = 32,
    parameter int TW   = 24
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*CFGW-1:0] req_cfg;
    logic [NREQ-1:0]      req_ready;
    logic [NMVU-1:0]      mvu_start;
    logic [NMVU*CFGW-1:0] mvu_cfg;
    logic [NMVU-1:0]      mvu_done;
    logic [NMVU-1:0]      mvu_busy;
    logic [NREQ-1:0]      done_irq;
    logic [NREQ-1:0]      timeout_err;
    logic [TW-1:0]        timeout_cycles;

    modport master (
        output req_valid, req_cfg, mvu_done, timeout_cycles,
        input  req_ready, mvu_start, mvu_cfg, mvu_busy, done_irq, timeout_err
    );

    modport slave (
        input  req_valid, req_cfg, mvu_done, timeout_cycles,
        output req_ready, mvu_start, mvu_cfg, mvu_busy, done_irq, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mvu_job_sched.sv
`default_nettype none
// ============================================================================
// Module      : mvu_job_sched
// Description : Round-robin job scheduler dispatching hart requests onto a
//               shared pool of MVUs, with per-MVU watchdog.
//   clk  : single rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mvu_job_sched_if.slave (requests, MVU handshake, notifications)
// Revision    : 1.0 - initial release
// ============================================================================
module mvu_job_sched #(
    parameter int NREQ = 8,
    parameter int NMVU = 8,
    parameter int CFGW = 32,
    parameter int TW   = 24
) (
    input  logic              clk,
    input  logic              rst,
    mvu_job_sched_if.slave    bus
);
    localparam int c_OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_RUN   = 2'd2;
    localparam logic [1:0] c_S_DRAIN = 2'd3;

    logic [1:0]           r_state     [NMVU];
    logic [1:0]           w_state_nxt [NMVU];
    logic [c_OW-1:0]      r_owner     [NMVU];
    logic [TW-1:0]        r_cnt       [NMVU];
    logic [NMVU*CFGW-1:0] r_mvu_cfg;
    logic [NREQ-1:0]      r_outst;
    logic [c_OW-1:0]      r_ptr;
    logic [NREQ-1:0]      r_done_irq;
    logic [NREQ-1:0]      r_timeout_err;

    logic [NREQ-1:0]      w_elig;
    logic [NREQ-1:0]      w_ready;
    logic [c_OW-1:0]      w_win;
    logic [c_OW-1:0]      w_idx;
    logic                 w_win_vld;
    logic                 w_accept;
    logic                 w_found;
    logic [NMVU-1:0]      w_idle;
    logic [NMVU-1:0]      w_grant_mvu;
    logic [NMVU-1:0]      w_wd_hit;
    logic [NMVU-1:0]      w_run_done;
    logic [NMVU-1:0]      w_run_expire;
    logic [NMVU-1:0]      w_busy;
    logic [NMVU-1:0]      w_start;
    logic [NREQ-1:0]      w_done_set;
    logic [NREQ-1:0]      w_to_set;

    // Arbitration: scan from the pointer downward in reverse so the
    // candidate closest to the pointer is the last (winning) assignment.
    always_comb begin
        w_elig    = bus.req_valid & ~r_outst;
        w_win     = '0;
        w_win_vld = 1'b0;
        w_idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (int'(r_ptr) + k >= NREQ) begin
                w_idx = c_OW'(int'(r_ptr) + k - NREQ);
            end else begin
                w_idx = c_OW'(int'(r_ptr) + k);
            end
            if (w_elig[w_idx]) begin
                w_win     = w_idx;
                w_win_vld = 1'b1;
            end
        end

        for (int m = 0; m < NMVU; m++) begin
            w_idle[m]  = (r_state[m] == c_S_IDLE);
            w_busy[m]  = (r_state[m] != c_S_IDLE);
            w_start[m] = (r_state[m] == c_S_START);
        end

        w_accept = w_win_vld && (|w_idle);
        w_ready  = '0;
        if (w_accept) begin
            w_ready[w_win] = 1'b1;
        end

        // Lowest-index idle MVU receives the accepted job.
        w_grant_mvu = '0;
        w_found     = 1'b0;
        for (int m = 0; m < NMVU; m++) begin
            if (w_idle[m] && !w_found) begin
                w_grant_mvu[m] = w_accept;
                w_found        = 1'b1;
            end
        end
    end

    // Per-MVU next-state logic. Completion takes priority over watchdog
    // expiry when both occur in the same RUN cycle.
    always_comb begin
        for (int m = 0; m < NMVU; m++) begin
            w_state_nxt[m]  = r_state[m];
            w_run_done[m]   = 1'b0;
            w_run_expire[m] = 1'b0;
            w_wd_hit[m]     = (bus.timeout_cycles != '0) &&
                              (r_cnt[m] == (bus.timeout_cycles - TW'(1)));
            case (r_state[m])
                c_S_IDLE:  if (w_grant_mvu[m]) w_state_nxt[m] = c_S_START;
                c_S_START: w_state_nxt[m] = c_S_RUN;
                c_S_RUN: begin
                    if (bus.mvu_done[m]) begin
                        w_state_nxt[m] = c_S_IDLE;
                        w_run_done[m]  = 1'b1;
                    end else if (w_wd_hit[m]) begin
                        w_state_nxt[m]  = c_S_DRAIN;
                        w_run_expire[m] = 1'b1;
                    end
                end
                c_S_DRAIN: if (bus.mvu_done[m]) w_state_nxt[m] = c_S_IDLE;
                default:   w_state_nxt[m] = c_S_IDLE;
            endcase
        end

        w_done_set = '0;
        w_to_set   = '0;
        for (int m = 0; m < NMVU; m++) begin
            if (w_run_done[m])   w_done_set[r_owner[m]] = 1'b1;
            if (w_run_expire[m]) w_to_set[r_owner[m]]   = 1'b1;
        end
    end

    // Per-MVU state, watchdog counter, owner and configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < NMVU; m++) begin
                r_state[m] <= c_S_IDLE;
                r_owner[m] <= '0;
                r_cnt[m]   <= '0;
            end
            r_mvu_cfg <= '0;
        end else begin
            for (int m = 0; m < NMVU; m++) begin
                r_state[m] <= w_state_nxt[m];
                // Counter is 0 in the first RUN cycle and counts RUN cycles.
                r_cnt[m]   <= (r_state[m] == c_S_RUN) ? r_cnt[m] + TW'(1) : '0;
                if (w_grant_mvu[m]) begin
                    r_owner[m]                   <= w_win;
                    r_mvu_cfg[m*CFGW +: CFGW]    <= bus.req_cfg[w_win*CFGW +: CFGW];
                end
            end
        end
    end

    // Hart-side bookkeeping. The outstanding flag drops at the end of the
    // notification cycle, so a hart cannot re-request while its pulse is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= '0;
            r_outst       <= '0;
            r_done_irq    <= '0;
            r_timeout_err <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= (int'(w_win) == NREQ - 1) ? '0 : w_win + c_OW'(1);
            end
            r_outst       <= (r_outst & ~(r_done_irq | r_timeout_err)) | w_ready;
            r_done_irq    <= w_done_set;
            r_timeout_err <= w_to_set;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.mvu_start   = w_start;
    assign bus.mvu_busy    = w_busy;
    assign bus.mvu_cfg     = r_mvu_cfg;
    assign bus.done_irq    = r_done_irq;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire
